note_sequencer: RTL and testbench

Playback controller between the song-selection FSM and the song ROM / tone generator. On each start pulse it latches the selected song. It then walks that song's note words in ROM, holds each note for its encoded duration in timebase ticks, and supports pause/resume. It flags end of song so upstream logic can advance, or it loops the song itself.

---
 rtl/note_sequencer_pkg.sv | 35 +++
 rtl/note_sequencer_dur_counter.sv | 34 +++
 rtl/note_sequencer.sv | 171 +++++++++++++++++
 tb/tb_note_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_sequencer_pkg.sv
// Shared constants for the note sequencer and the song-selection FSM.
package note_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_PLAY   = 3'd3,
    ST_PAUSED = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Note code 0 is silence; duration 0 marks the end of a song.
  localparam int NOTE_REST  = 0;
  localparam int END_MARK   = 0;

  localparam int SONG_COUNT = 4;
  localparam int SONG_W     = $clog2(SONG_COUNT);

  // ROM word layout: {note, duration}, duration in the low bits.
  localparam int DUR_LSB = 0;

  function automatic int dur_msb(input int dur_w);
    return dur_w - 1;
  endfunction

  function automatic int note_lsb(input int dur_w);
    return dur_w;
  endfunction

  function automatic int note_msb(input int note_w, input int dur_w);
    return note_w + dur_w - 1;
  endfunction

endpackage

// File: rtl/note_sequencer_dur_counter.sv
// Note-duration down-counter: loaded with the duration field, decremented
// on timebase ticks unless frozen, flags expiry on the tick that ends the note.
module note_sequencer_dur_counter
  import note_sequencer_pkg::*;
#(
  parameter int DUR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [DUR_W-1:0] i_load_val,
  input  logic             i_tick,
  input  logic             i_freeze,
  output logic             o_expire
);

  logic [DUR_W-1:0] r_cnt;
  logic             w_step;

  assign w_step   = i_tick & ~i_freeze;
  assign o_expire = w_step & (r_cnt == DUR_W'(1));

  // Load wins over counting; the count never wraps below zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (w_step && (r_cnt != '0)) begin
      r_cnt <= r_cnt - DUR_W'(1);
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Song playback controller: latches the selected song on start, walks its
// ROM words, holds each note for its duration in ticks, supports pause.
//
//   state  | meaning
//   IDLE   | after reset, silent, waiting for start
//   FETCH  | ROM read issued for {song, idx}
//   LOAD   | ROM word valid: latch note/duration or handle end marker
//   PLAY   | note sounding, duration counting down on ticks
//   PAUSED | note muted, count frozen, held note kept for resume
//   DONE   | song finished (LOOP=0), silent, waiting for start
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int IDX_W  = 6,
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 4,
  parameter int LOOP   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [SONG_W-1:0]       select,
  input  logic                    pause,
  input  logic                    tick,
  output logic [SONG_W+IDX_W-1:0] mem_addr,
  output logic                    mem_rd,
  input  logic [NOTE_W+DUR_W-1:0] mem_data,
  output logic [NOTE_W-1:0]       note,
  output logic                    playing,
  output logic                    song_end
);

  localparam int NOTE_MSB = note_msb(NOTE_W, DUR_W);
  localparam int NOTE_LSB = note_lsb(DUR_W);
  localparam int DUR_MSB  = dur_msb(DUR_W);
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  state_t                    r_state, w_state_nxt;
  logic [SONG_W-1:0]         r_song, w_song_nxt;
  logic [IDX_W-1:0]          r_idx, w_idx_nxt;
  logic                      r_pend, w_pend_nxt, w_pend_eff;
  logic [NOTE_W-1:0]         r_note, w_note_nxt;
  logic                      r_mem_rd;
  logic [SONG_W+IDX_W-1:0]   r_mem_addr;
  logic                      r_song_end;
  logic                      w_end_evt;
  logic                      w_load;
  logic                      w_freeze;
  logic                      w_expire;
  logic                      w_active;
  logic [NOTE_W-1:0]         w_word_note;
  logic [DUR_W-1:0]          w_word_dur;

  assign w_word_note = mem_data[NOTE_MSB:NOTE_LSB];
  assign w_word_dur  = mem_data[DUR_MSB:DUR_LSB];

  // A start or pause in the same cycle discards the tick.
  assign w_freeze = (r_state != ST_PLAY) | pause | start;

  note_sequencer_dur_counter #(
    .DUR_W (DUR_W)
  ) u_dur (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_word_dur),
    .i_tick     (tick),
    .i_freeze   (w_freeze),
    .o_expire   (w_expire)
  );

  // A pause landing in LOAD counts together with any pause seen in FETCH.
  assign w_pend_eff = r_pend ^ pause;

  // Next-state, index, pause-pending and note decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_song_nxt  = r_song;
    w_idx_nxt   = r_idx;
    w_pend_nxt  = r_pend;
    w_note_nxt  = r_note;
    w_end_evt   = 1'b0;
    w_load      = 1'b0;
    if (start) begin
      w_song_nxt  = select;
      w_idx_nxt   = '0;
      w_pend_nxt  = 1'b0;
      w_state_nxt = ST_FETCH;
    end else begin
      case (r_state)
        ST_FETCH: begin
          w_state_nxt = ST_LOAD;
          if (pause) w_pend_nxt = ~r_pend;
        end
        ST_LOAD: begin
          if (w_word_dur == DUR_W'(END_MARK)) begin
            w_note_nxt = NOTE_W'(NOTE_REST);
            w_end_evt  = 1'b1;
            w_pend_nxt = w_pend_eff;
            if (LOOP != 0) begin
              w_idx_nxt   = '0;
              w_state_nxt = ST_FETCH;
            end else begin
              w_state_nxt = ST_DONE;
            end
          end else begin
            w_note_nxt  = w_word_note;
            w_load      = 1'b1;
            w_pend_nxt  = 1'b0;
            w_state_nxt = w_pend_eff ? ST_PAUSED : ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (pause) begin
            w_state_nxt = ST_PAUSED;
          end else if (w_expire) begin
            if (r_idx != IDX_LAST) begin
              w_idx_nxt   = r_idx + IDX_W'(1);
              w_state_nxt = ST_FETCH;
            end else begin
              // Running off the end of the song acts like an end marker.
              w_note_nxt  = NOTE_W'(NOTE_REST);
              w_end_evt   = 1'b1;
              w_idx_nxt   = '0;
              w_state_nxt = (LOOP != 0) ? ST_FETCH : ST_DONE;
            end
          end
        end
        ST_PAUSED: begin
          if (pause) w_state_nxt = ST_PLAY;
        end
        default: begin
        end
      endcase
    end
  end

  // State and registered ROM interface; the address only moves on FETCH entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_song     <= '0;
      r_idx      <= '0;
      r_pend     <= 1'b0;
      r_note     <= '0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_song_end <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_song     <= w_song_nxt;
      r_idx      <= w_idx_nxt;
      r_pend     <= w_pend_nxt;
      r_note     <= w_note_nxt;
      r_mem_rd   <= (w_state_nxt == ST_FETCH);
      r_song_end <= w_end_evt;
      if (w_state_nxt == ST_FETCH) begin
        r_mem_addr <= {w_song_nxt, w_idx_nxt};
      end
    end
  end

  // Previous note keeps sounding through FETCH/LOAD to avoid a gap.
  assign w_active = (r_state == ST_FETCH) | (r_state == ST_LOAD) | (r_state == ST_PLAY);
  assign playing  = w_active;
  assign note     = w_active ? r_note : NOTE_W'(NOTE_REST);
  assign mem_rd   = r_mem_rd;
  assign mem_addr = r_mem_addr;
  assign song_end = r_song_end;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: two instances (LOOP=0 and LOOP=1) driven by the
// same stimulus and checked every cycle against a playback model.
module tb_note_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, pause, tick;
  logic [1:0] select;
  logic [7:0] addr0, addr1;
  logic       rd0, rd1, pl0, pl1, end0, end1;
  logic [5:0] note0, note1;
  logic [9:0] data0, data1;
  logic [9:0] rom [256];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  note_sequencer #(.IDX_W(6), .NOTE_W(6), .DUR_W(4), .LOOP(0)) u0 (
    .clk(clk), .reset(reset), .start(start), .select(select), .pause(pause),
    .tick(tick), .mem_addr(addr0), .mem_rd(rd0), .mem_data(data0),
    .note(note0), .playing(pl0), .song_end(end0));

  note_sequencer #(.IDX_W(6), .NOTE_W(6), .DUR_W(4), .LOOP(1)) u1 (
    .clk(clk), .reset(reset), .start(start), .select(select), .pause(pause),
    .tick(tick), .mem_addr(addr1), .mem_rd(rd1), .mem_data(data1),
    .note(note1), .playing(pl1), .song_end(end1));

  // synchronous ROM, one cycle latency
  always @(posedge clk) begin
    data0 <= rom[addr0];
    data1 <= rom[addr1];
  end

  // Playback model: where in the song we are and what is audible.
  // phase 0 = word being read, 1 = word arriving, 2 = note sounding.
  typedef struct packed {
    bit       busy;
    bit [1:0] phase;
    bit       paused;
    bit       pend;
    bit [1:0] song;
    bit [5:0] idx;
    bit [3:0] left;
    bit [5:0] held;
    bit       endp;
    bit [7:0] addr;
  } m_t;

  m_t m0, m1;

  function automatic m_t song_over(m_t n, bit loop_en);
    n.held = 6'd0;
    n.endp = 1'b1;
    if (loop_en) begin
      n.idx   = 6'd0;
      n.phase = 2'd0;
      n.addr  = {n.song, 6'd0};
    end else begin
      n.busy   = 1'b0;
      n.paused = 1'b0;
    end
    return n;
  endfunction

  function automatic m_t mstep(m_t s, bit loop_en, bit st, logic [1:0] sel, bit pz, bit tk);
    m_t n;
    logic [9:0] w;
    bit p;
    n = s;
    n.endp = 1'b0;
    if (st) begin
      n.busy = 1'b1; n.phase = 2'd0; n.paused = 1'b0; n.pend = 1'b0;
      n.song = sel; n.idx = 6'd0; n.addr = {sel, 6'd0};
      return n;
    end
    if (!s.busy) return n;
    case (s.phase)
      2'd0: begin
        n.phase = 2'd1;
        if (pz) n.pend = !s.pend;
      end
      2'd1: begin
        w = rom[{s.song, s.idx}];
        p = s.pend ^ pz;
        if (w[3:0] == 4'd0) begin
          n.pend = p;
          n = song_over(n, loop_en);
        end else begin
          n.held = w[9:4]; n.left = w[3:0]; n.phase = 2'd2;
          n.paused = p; n.pend = 1'b0;
        end
      end
      default: begin
        if (s.paused) begin
          if (pz) n.paused = 1'b0;
        end else if (pz) begin
          n.paused = 1'b1;
        end else if (tk) begin
          n.left = s.left - 4'd1;
          if (n.left == 4'd0) begin
            if (s.idx != 6'd63) begin
              n.idx = s.idx + 6'd1; n.phase = 2'd0; n.addr = {s.song, n.idx};
            end else begin
              n.idx = 6'd0;
              n = song_over(n, loop_en);
            end
          end
        end
      end
    endcase
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      m0 <= mstep(m0, 1'b0, start, select, pause, tick);
      m1 <= mstep(m1, 1'b1, start, select, pause, tick);
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_dut(input string nm, input m_t m, input logic [7:0] a, input logic r,
                         input logic [5:0] nt, input logic pl, input logic e);
    cmp({nm, ".mem_addr"}, 32'(a), 32'(m.addr));
    cmp({nm, ".mem_rd"},   32'(r), 32'(m.busy && m.phase == 2'd0));
    cmp({nm, ".note"},     32'(nt), (m.busy && m.phase == 2'd2 && m.paused) ? 32'd0 : 32'(m.held));
    cmp({nm, ".playing"},  32'(pl), 32'(m.busy && !m.paused));
    cmp({nm, ".song_end"}, 32'(e), 32'(m.endp));
  endtask

  // the one compare process against the model
  always @(negedge clk) begin
    if (!reset) begin
      chk_dut("u0", m0, addr0, rd0, note0, pl0, end0);
      chk_dut("u1", m1, addr1, rd1, note1, pl1, end1);
    end
  end

  task automatic drive(input bit s, input logic [1:0] sel, input bit p, input bit t);
    @(negedge clk);
    start = s; select = sel; pause = p; tick = t;
  endtask

  int q0[$];
  int q1[$];
  int e0, e1;
  bit seen5;

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clr_rec();
    q0.delete(); q1.delete(); e0 = 0; e1 = 0; seen5 = 1'b0;
  endtask

  task automatic rec();
    if (rd0) q0.push_back(int'(addr0));
    if (rd1) q1.push_back(int'(addr1));
    if (end0) e0++;
    if (end1) e1++;
    if (e1 > 0 && note1 == 6'd5) seen5 = 1'b1;
  endtask

  task automatic run(input int ncyc, input int period, input logic [1:0] sel);
    for (int i = 0; i < ncyc; i++) begin
      drive(1'b0, sel, 1'b0, (i % period) == period - 1);
      rec();
    end
  endtask

  task automatic wait_note5(input string nm);
    for (int k = 0; k < 12 && note0 !== 6'd5; k++) drive(1'b0, 2'd1, 1'b0, 1'b0);
    cmp(nm, 32'(note0), 32'd5);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "bench timed out");
  end

  initial begin
    int  n;
    bit  hit;
    bit  t;
    start = 0; pause = 0; tick = 0; select = 0;
    reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      rom[i] = {6'($urandom), 4'($urandom_range(1, 15))};
      if ((i < 64 || (i >= 128 && i < 192)) && ($urandom % 8 == 0)) rom[i][3:0] = 4'd0;
      if (i >= 192) rom[i][3:0] = 4'd1;
    end
    rom[64] = {6'd5, 4'd3};
    rom[65] = {6'd9, 4'd1};
    rom[66] = {6'd0, 4'd0};

    repeat (3) @(negedge clk);
    cmp("rst.note0", 32'(note0), 32'd0);
    cmp("rst.playing0", 32'(pl0), 32'd0);
    cmp("rst.mem_rd0", 32'(rd0), 32'd0);
    cmp("rst.mem_addr0", 32'(addr0), 32'd0);
    cmp("rst.song_end0", 32'(end0), 32'd0);
    cmp("rst.mem_addr1", 32'(addr1), 32'd0);
    reset = 1'b0;

    // song 1, tick every 4 clk
    clr_rec();
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    rec();
    run(60, 4, 2'd1);
    cmp("A.fetch_count", 32'(q0.size()), 32'd3);
    cmp("A.fetch0", 32'(qat(q0, 0)), 32'd64);
    cmp("A.fetch1", 32'(qat(q0, 1)), 32'd65);
    cmp("A.fetch2", 32'(qat(q0, 2)), 32'd66);
    cmp("A.end_count", 32'(e0), 32'd1);
    cmp("A.note_done", 32'(note0), 32'd0);
    cmp("A.playing_done", 32'(pl0), 32'd0);
    cmp("A.loop_refetch", 32'(qat(q1, 3)), 32'd64);
    cmp("A.loop_note5_again", 32'(seen5), 32'd1);

    // pause after one tick of note 5
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    wait_note5("B.note5");
    drive(1'b0, 2'd1, 1'b0, 1'b1);
    drive(1'b0, 2'd1, 1'b0, 1'b0);
    drive(1'b0, 2'd1, 1'b1, 1'b0);
    drive(1'b0, 2'd1, 1'b0, 1'b0);
    cmp("B.note_paused", 32'(note0), 32'd0);
    cmp("B.playing_paused", 32'(pl0), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'd1, 1'b0, 1'b1);
      drive(1'b0, 2'd1, 1'b0, 1'b0);
    end
    cmp("B.addr_frozen", 32'(addr0), 32'd64);
    cmp("B.note_still_muted", 32'(note0), 32'd0);
    drive(1'b0, 2'd1, 1'b1, 1'b0);
    drive(1'b0, 2'd1, 1'b0, 1'b0);
    cmp("B.note_resumed", 32'(note0), 32'd5);
    n = 0;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (rd0 && addr0 == 8'd65) begin
        hit = 1'b1;
      end else begin
        t = (i % 4 == 0);
        drive(1'b0, 2'd1, 1'b0, t);
        if (t) n++;
      end
    end
    cmp("B.reached_next", 32'(hit), 32'd1);
    cmp("B.ticks_after_resume", 32'(n), 32'd2);

    // restart onto song 2 mid-note
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    wait_note5("C.note5");
    drive(1'b1, 2'd2, 1'b0, 1'b0);
    drive(1'b0, 2'd2, 1'b0, 1'b0);
    cmp("C.mem_rd", 32'(rd0), 32'd1);
    cmp("C.mem_addr", 32'(addr0), 32'd128);
    cmp("C.no_song_end", 32'(end0), 32'd0);

    // song 3: 64 words of duration 1, no marker
    clr_rec();
    drive(1'b1, 2'd3, 1'b0, 1'b0);
    rec();
    run(250, 1, 2'd3);
    cmp("D.fetch_count", 32'(q0.size()), 32'd64);
    cmp("D.last_addr", 32'(qat(q0, 63)), 32'd255);
    cmp("D.end_count", 32'(e0), 32'd1);
    cmp("D.loop_wrap", 32'(qat(q1, 64)), 32'd192);

    // asynchronous reset in the middle of a note
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    wait_note5("E.note5");
    #1 reset = 1'b1;
    #1;
    cmp("E.note", 32'(note0), 32'd0);
    cmp("E.playing", 32'(pl0), 32'd0);
    cmp("E.mem_addr", 32'(addr0), 32'd0);
    cmp("E.mem_rd", 32'(rd0), 32'd0);
    cmp("E.song_end", 32'(end0), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 2'd1, 1'b0, 1'b0);
    drive(1'b0, 2'd1, 1'b0, 1'b0);
    cmp("E.restart_addr", 32'(addr0), 32'd64);
    cmp("E.restart_rd", 32'(rd0), 32'd1);

    // randomized traffic, model compares every cycle
    drive(1'b1, 2'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      drive($urandom % 48 == 0, 2'($urandom), $urandom % 10 == 0, $urandom % 3 == 0);
    end
    repeat (4) drive(1'b0, 2'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
